// File: rtl/level_code_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// level_code_ctrl_pkg
//   Shared definitions for the CAVLC level-encoding controller: FSM state
//   encoding, escape-code constants and the suffixLength initialisation rule.
//   Imported by level_code_ctrl (top) and level_code_ctrl_map (datapath).
// -----------------------------------------------------------------------------
package level_code_ctrl_pkg;

    // Escape structure of level_prefix / level_suffix.
    localparam int ESC_PREFIX    = 15;  // prefix value that signals the escape suffix
    localparam int ESC4_BASE     = 14;  // sl==0: first code using the 4-bit suffix
    localparam int ESC4_SUFFIX_W = 4;   // sl==0: width of the short escape suffix
    localparam int ESC12_BASE    = 30;  // sl==0: first code using the 12-bit suffix
    localparam int ESC_SUFFIX_W  = 12;  // width of the long escape suffix
    localparam int SL_MAX        = 6;   // suffixLength saturates here

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FETCH,
        ST_CALC,
        ST_ISSUE,
        ST_WAIT,
        ST_UPDATE,
        ST_DONE
    } state_t;

    // Starting suffixLength for a block: dense blocks without three trailing
    // ones start at 1 so that large first levels stay short.
    function automatic logic [2:0] init_sl(input logic [4:0] tc, input logic [1:0] t1);
        return (tc > 5'd10 && t1 < 2'd3) ? 3'd1 : 3'd0;
    endfunction

endpackage

// File: rtl/level_code_ctrl_map.sv
// -----------------------------------------------------------------------------
// level_code_ctrl_map
//   Purely combinational level mapping: one signed level plus the current
//   suffixLength context -> level_prefix, suffix value, suffix size and the
//   adapted suffixLength for the next level.
//   Macro LEVEL_RANGE_CHK_EN adds esc_ovf (escape suffix does not fit CODE_W).
// Ports
//   lvl           in  LEVEL_W  signed nonzero level
//   sl            in  3        current suffixLength (0..6)
//   first         in  1        level is the first non-trailing-one of the block
//   trailing_ones in  2        TrailingOnes of the block
//   level_prefix  out 4        level_prefix (0..15)
//   level_code    out CODE_W   suffix value (truncated)
//   suffix_len    out 4        suffix size in bits (0..12)
//   sl_next       out 3        suffixLength after this level
//   esc_ovf       out 1        (LEVEL_RANGE_CHK_EN only) escape suffix overflow
// -----------------------------------------------------------------------------
module level_code_ctrl_map
    import level_code_ctrl_pkg::*;
#(
    parameter int LEVEL_W = 16,
    parameter int CODE_W  = 12
) (
    input  logic signed [LEVEL_W-1:0] lvl,
    input  logic        [2:0]         sl,
    input  logic                      first,
    input  logic        [1:0]         trailing_ones,
    output logic        [3:0]         level_prefix,
    output logic        [CODE_W-1:0]  level_code,
    output logic        [3:0]         suffix_len,
    output logic        [2:0]         sl_next
`ifdef LEVEL_RANGE_CHK_EN
    ,
    output logic                      esc_ovf
`endif
);

    // Two extra bits hold 2*|lvl| without overflow.
    localparam int LC_W = LEVEL_W + 2;

    logic signed [LC_W-1:0] lvl_x;
    logic signed [LC_W-1:0] lc_raw;
    logic signed [LC_W-1:0] lc_adj;
    logic        [LC_W-1:0] lc;
    logic        [LC_W-1:0] lvl_abs;
    logic        [LC_W-1:0] thresh;
    logic        [2:0]      sl_one;

    // NOTE: every output gets a default at the top of the block so no path
    // leaves a variable unassigned (which would infer a latch).
    always_comb begin
        level_prefix = '0;
        level_code   = '0;
        suffix_len   = '0;
`ifdef LEVEL_RANGE_CHK_EN
        esc_ovf      = 1'b0;
`endif

        lvl_x   = {{2{lvl[LEVEL_W-1]}}, lvl};
        lc_raw  = (lvl > 0) ? (lvl_x <<< 1) - LC_W'(2) : -(lvl_x <<< 1) - LC_W'(1);
        // The first coded level cannot be +-1 when fewer than 3 trailing ones
        // were present, so its code space is shifted down by two.
        lc_adj  = (first && trailing_ones < 2'd3) ? lc_raw - LC_W'(2) : lc_raw;
        lc      = lc_adj[LC_W-1] ? '0 : lc_adj;
        lvl_abs = lvl_x[LC_W-1] ? -lvl_x : lvl_x;
        thresh  = LC_W'(ESC_PREFIX) << sl;

        if (sl == 3'd0) begin
            if (lc < LC_W'(ESC4_BASE)) begin
                level_prefix = lc[3:0];
            end else if (lc < LC_W'(ESC12_BASE)) begin
                level_prefix = 4'(ESC4_BASE);
                level_code   = CODE_W'(lc - LC_W'(ESC4_BASE));
                suffix_len   = 4'(ESC4_SUFFIX_W);
            end else begin
                level_prefix = 4'(ESC_PREFIX);
                level_code   = CODE_W'(lc - LC_W'(ESC12_BASE));
                suffix_len   = 4'(ESC_SUFFIX_W);
`ifdef LEVEL_RANGE_CHK_EN
                esc_ovf      = (lc - LC_W'(ESC12_BASE)) > LC_W'((1 << CODE_W) - 1);
`endif
            end
        end else if (lc < thresh) begin
            level_prefix = 4'(lc >> sl);
            level_code   = CODE_W'(lc & ((LC_W'(1) << sl) - LC_W'(1)));
            suffix_len   = {1'b0, sl};
        end else begin
            level_prefix = 4'(ESC_PREFIX);
            level_code   = CODE_W'(lc - thresh);
            suffix_len   = 4'(ESC_SUFFIX_W);
`ifdef LEVEL_RANGE_CHK_EN
            esc_ovf      = (lc - thresh) > LC_W'((1 << CODE_W) - 1);
`endif
        end

        // Adaptation compares against the already-promoted suffixLength.
        sl_one  = (sl == 3'd0) ? 3'd1 : sl;
        sl_next = sl_one;
        if (lvl_abs > (LC_W'(3) << (sl_one - 3'd1)) && sl_one < 3'(SL_MAX))
            sl_next = sl_one + 3'd1;
    end

endmodule

// File: rtl/level_code_ctrl.sv
// -----------------------------------------------------------------------------
// level_code_ctrl
//   Upstream controller of the CAVLC level-encoding path. Accepts the
//   non-trailing-one levels of a block, maps each one to prefix/suffix fields,
//   fires the prefix emitter and suffix serializer together and waits for both
//   to finish before taking the next level. suffixLength adapts per level.
//   Macro LEVEL_RANGE_CHK_EN adds the sticky per-block range_err output.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   blk_start                 begin a block (IDLE only), latches total_coeff / trailing_ones
//   total_coeff, trailing_ones block statistics
//   lvl_valid/lvl_ready/lvl_data/lvl_last  level stream
//   prefix_start, level_prefix, prefix_finish  prefix emitter handshake
//   suffix_start, level_code, suffix_len, suffix_finish  suffix serializer handshake
//   busy                      high from blk_start until blk_done
//   blk_done                  one-cycle end-of-block pulse
//   range_err                 (LEVEL_RANGE_CHK_EN only) escape suffix overflowed CODE_W
// -----------------------------------------------------------------------------
module level_code_ctrl
    import level_code_ctrl_pkg::*;
#(
    parameter int LEVEL_W = 16,
    parameter int CODE_W  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      blk_start,
    input  logic        [4:0]         total_coeff,
    input  logic        [1:0]         trailing_ones,
    input  logic                      lvl_valid,
    output logic                      lvl_ready,
    input  logic signed [LEVEL_W-1:0] lvl_data,
    input  logic                      lvl_last,
    output logic                      prefix_start,
    output logic        [3:0]         level_prefix,
    input  logic                      prefix_finish,
    output logic                      suffix_start,
    output logic        [CODE_W-1:0]  level_code,
    output logic        [3:0]         suffix_len,
    input  logic                      suffix_finish,
    output logic                      busy,
    output logic                      blk_done
`ifdef LEVEL_RANGE_CHK_EN
    ,
    output logic                      range_err
`endif
);

    state_t state, state_nxt;

    logic        [4:0]         tc_q;
    logic        [1:0]         t1_q;
    logic        [2:0]         sl_q;
    logic                      first_q;
    logic signed [LEVEL_W-1:0] lvl_q;
    logic                      last_q;
    logic                      pfin_q;
    logic                      sfin_q;
    logic                      both_done;

    logic        [3:0]         map_prefix;
    logic        [CODE_W-1:0]  map_code;
    logic        [3:0]         map_len;
    logic        [2:0]         map_sl_next;
`ifdef LEVEL_RANGE_CHK_EN
    logic                      map_esc_ovf;
`endif

    level_code_ctrl_map #(
        .LEVEL_W (LEVEL_W),
        .CODE_W  (CODE_W)
    ) u_map (
        .lvl           (lvl_q),
        .sl            (sl_q),
        .first         (first_q),
        .trailing_ones (t1_q),
        .level_prefix  (map_prefix),
        .level_code    (map_code),
        .suffix_len    (map_len),
        .sl_next       (map_sl_next)
`ifdef LEVEL_RANGE_CHK_EN
        ,
        .esc_ovf       (map_esc_ovf)
`endif
    );

    // A finish counts whether it was seen in an earlier WAIT cycle or now.
    assign both_done = (pfin_q | prefix_finish) && (sfin_q | suffix_finish);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (blk_start) state_nxt = ST_INIT;
            ST_INIT:   state_nxt = (tc_q == {3'b000, t1_q}) ? ST_DONE : ST_FETCH;
            ST_FETCH:  if (lvl_valid) state_nxt = ST_CALC;
            ST_CALC:   state_nxt = ST_ISSUE;
            ST_ISSUE:  state_nxt = ST_WAIT;
            ST_WAIT:   if (both_done) state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = last_q ? ST_DONE : ST_FETCH;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        lvl_ready    = (state == ST_FETCH);
        prefix_start = (state == ST_ISSUE);
        suffix_start = (state == ST_ISSUE);
        busy         = (state != ST_IDLE);
        blk_done     = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q         <= '0;
            t1_q         <= '0;
            sl_q         <= '0;
            first_q      <= 1'b0;
            lvl_q        <= '0;
            last_q       <= 1'b0;
            pfin_q       <= 1'b0;
            sfin_q       <= 1'b0;
            level_prefix <= '0;
            level_code   <= '0;
            suffix_len   <= '0;
`ifdef LEVEL_RANGE_CHK_EN
            range_err    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (blk_start) begin
                        tc_q      <= total_coeff;
                        t1_q      <= trailing_ones;
`ifdef LEVEL_RANGE_CHK_EN
                        range_err <= 1'b0;
`endif
                    end
                end
                ST_INIT: begin
                    sl_q    <= init_sl(tc_q, t1_q);
                    first_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (lvl_valid) begin
                        lvl_q  <= lvl_data;
                        last_q <= lvl_last;
                    end
                end
                ST_CALC: begin
                    // Held from here through WAIT so downstream sees stable fields.
                    level_prefix <= map_prefix;
                    level_code   <= map_code;
                    suffix_len   <= map_len;
`ifdef LEVEL_RANGE_CHK_EN
                    range_err    <= range_err | map_esc_ovf;
`endif
                end
                ST_ISSUE: begin
                    // Finish levels from the previous level are stale until
                    // downstream sees this start, so they are not sampled here.
                    pfin_q <= 1'b0;
                    sfin_q <= 1'b0;
                end
                ST_WAIT: begin
                    pfin_q <= pfin_q | prefix_finish;
                    sfin_q <= sfin_q | suffix_finish;
                end
                ST_UPDATE: begin
                    first_q <= 1'b0;
                    sl_q    <= map_sl_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_level_code_ctrl.sv
// -----------------------------------------------------------------------------
// tb_level_code_ctrl
//   Directed self-checking bench for level_code_ctrl. A behavioural responder
//   models the prefix emitter / suffix serializer with per-level finish delays;
//   a monitor records every issued (prefix, suffix, size) triple and handshake
//   events, which are compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_level_code_ctrl;

    localparam int LEVEL_W = 16;
    localparam int CODE_W  = 12;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      blk_start;
    logic        [4:0]         total_coeff;
    logic        [1:0]         trailing_ones;
    logic                      lvl_valid;
    logic                      lvl_ready;
    logic signed [LEVEL_W-1:0] lvl_data;
    logic                      lvl_last;
    logic                      prefix_start;
    logic        [3:0]         level_prefix;
    logic                      prefix_finish;
    logic                      suffix_start;
    logic        [CODE_W-1:0]  level_code;
    logic        [3:0]         suffix_len;
    logic                      suffix_finish;
    logic                      busy;
    logic                      blk_done;
`ifdef LEVEL_RANGE_CHK_EN
    logic                      range_err;
`endif

    level_code_ctrl #(.LEVEL_W(LEVEL_W), .CODE_W(CODE_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .blk_start     (blk_start),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones),
        .lvl_valid     (lvl_valid),
        .lvl_ready     (lvl_ready),
        .lvl_data      (lvl_data),
        .lvl_last      (lvl_last),
        .prefix_start  (prefix_start),
        .level_prefix  (level_prefix),
        .prefix_finish (prefix_finish),
        .suffix_start  (suffix_start),
        .level_code    (level_code),
        .suffix_len    (suffix_len),
        .suffix_finish (suffix_finish),
        .busy          (busy),
        .blk_done      (blk_done)
`ifdef LEVEL_RANGE_CHK_EN
        ,
        .range_err     (range_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // ---------------- cycle counter, monitor, downstream responder -----------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int pfx; int code; int len;} iss_t;
    iss_t iss_q[$];

    int n_start = 0, n_done = 0, n_ready = 0, ss_mis = 0, hs_viol = 0;
    int first_start_cyc = -1;
    int blk_cyc = 0;
    bit outstanding = 0, pseen = 0, sseen = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                outstanding = 0;
            end else begin
                if (suffix_start !== prefix_start) ss_mis++;
                if (lvl_ready === 1'b1) n_ready++;
                if (blk_done === 1'b1) n_done++;
                if (prefix_start === 1'b1) begin
                    n_start++;
                    iss_q.push_back('{int'(level_prefix), int'(level_code), int'(suffix_len)});
                    if (first_start_cyc < 0) first_start_cyc = cyc;
                    outstanding = 1; pseen = 0; sseen = 0;
                end else if (outstanding) begin
                    if (prefix_finish) pseen = 1;
                    if (suffix_finish) sseen = 1;
                    if (pseen && sseen) outstanding = 0;
                end
                if ((lvl_ready === 1'b1 || blk_done === 1'b1) && outstanding) hs_viol++;
            end
        end
    end

    int pre_dly = 1, suf_dly = 1;
    int pcnt = 0, scnt = 0;

    initial begin : responder
        prefix_finish = 1'b0;
        suffix_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prefix_finish = 1'b0; suffix_finish = 1'b0; pcnt = 0; scnt = 0;
            end else begin
                if (prefix_start === 1'b1) begin
                    prefix_finish = 1'b0; pcnt = pre_dly;
                end else if (pcnt > 0) begin
                    pcnt--;
                    if (pcnt == 0) prefix_finish = 1'b1;
                end
                if (suffix_start === 1'b1) begin
                    suffix_finish = 1'b0; scnt = suf_dly;
                end else if (scnt > 0) begin
                    scnt--;
                    if (scnt == 0) suffix_finish = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ---------------------------------------
    typedef struct {int lvl; int pfx; int code; int len; int pd; int sd;} vec_t;
    vec_t vq[$];

    task automatic add(input int lvl, input int pfx, input int code, input int len,
                       input int pd = 1, input int sd = 1);
        vq.push_back('{lvl, pfx, code, len, pd, sd});
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({lvl_ready, prefix_start, suffix_start, busy, blk_done,
                    level_prefix, suffix_len, level_code});
    endfunction

    task automatic start_block(input int tc, input int t1);
        @(posedge clk); #1;
        blk_start = 1'b1; total_coeff = 5'(tc); trailing_ones = 2'(t1); blk_cyc = cyc;
        @(posedge clk); #1;
        blk_start = 1'b0;
    endtask

    task automatic send_level(input int lvl, input bit last, input string tag);
        int t;
        lvl_valid = 1'b1; lvl_data = 16'(lvl); lvl_last = last;
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (lvl_ready === 1'b1) break;
            t++;
        end
        if (lvl_ready !== 1'b1) check({tag, " ready timeout"}, 32'(lvl_ready), 1);
        @(posedge clk); #1;
        lvl_valid = 1'b0; lvl_last = 1'b0;
    endtask

    task automatic wait_start(input int prev, input string tag);
        int t = 0;
        while (n_start <= prev && t < 200) begin @(posedge clk); #1; t++; end
        if (n_start <= prev) check({tag, " start timeout"}, 32'(n_start), 32'(prev + 1));
    endtask

    task automatic wait_done(input int prev, input string tag);
        int t = 0;
        while (n_done <= prev && t < 400) begin @(posedge clk); #1; t++; end
        if (n_done <= prev) check({tag, " done timeout"}, 32'(n_done), 32'(prev + 1));
    endtask

    task automatic run_block(input string name, input int tc, input int t1);
        int s0, d0, r0, n;
        s0 = n_start; d0 = n_done; r0 = n_ready; n = vq.size();
        iss_q.delete();
        first_start_cyc = -1;
        // First level is presented before blk_start to exercise min latency.
        if (n > 0) begin
            lvl_valid = 1'b1; lvl_data = 16'(vq[0].lvl); lvl_last = (n == 1);
        end
        start_block(tc, t1);
        check({name, " busy"}, 32'(busy), 1);
        for (int i = 0; i < n; i++) begin
            pre_dly = vq[i].pd; suf_dly = vq[i].sd;
            send_level(vq[i].lvl, i == n - 1, name);
            wait_start(s0 + i, name);
        end
        wait_done(d0, name);
        @(posedge clk); #1;
        check({name, " busy after done"}, 32'(busy), 0);
        check({name, " start pulses"}, 32'(n_start - s0), 32'(n));
        check({name, " ready cycles"}, 32'(n_ready - r0), 32'(n));
        check({name, " blk_done pulses"}, 32'(n_done - d0), 1);
        if (n > 0) check({name, " latency"}, 32'(first_start_cyc - blk_cyc), 4);
        for (int i = 0; i < n; i++) begin
            if (iss_q.size() > i) begin
                check($sformatf("%s L%0d prefix", name, i), 32'(iss_q[i].pfx),  32'(vq[i].pfx));
                check($sformatf("%s L%0d suffix", name, i), 32'(iss_q[i].code), 32'(vq[i].code));
                check($sformatf("%s L%0d size", name, i),   32'(iss_q[i].len),  32'(vq[i].len));
            end else begin
                check($sformatf("%s L%0d issued", name, i), 32'(iss_q.size()), 32'(i + 1));
            end
        end
        vq.delete();
    endtask

    // ---------------- directed sequence --------------------------------------
    initial begin : main
        int s0, d0;
        rst = 1'b1; blk_start = 1'b0; total_coeff = '0; trailing_ones = '0;
        lvl_valid = 1'b0; lvl_data = '0; lvl_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", all_outputs(), 0);
        rst = 1'b0;

        // TC=5,T1=1: +3 -> lc 2 (first adj), -5 at sl=1 -> lc 9.
        add(3, 2, 0, 0); add(-5, 4, 1, 1);
        run_block("blkA", 5, 1);
        // Same block with a third level reveals sl=2 after -5: +4 -> lc 6.
        add(3, 2, 0, 0); add(-5, 4, 1, 1); add(4, 1, 2, 2);
        run_block("blkA3", 5, 1);
        // T1=3: no first adjustment, sl=0 escape suffixes.
        add(8, 14, 0, 4);
        run_block("blkB8", 4, 3);
        add(16, 15, 0, 12);
        run_block("blkB16", 4, 3);
        // TC=11,T1=0: sl starts at 1, +2 first -> lc 0; sl stays 1 for +3 -> lc 4.
        add(2, 0, 0, 1); add(3, 2, 0, 1);
        run_block("blkC", 11, 0);
        // Finish ordering: suffix 3 cycles ahead of prefix, then simultaneous.
        // -1 first -> lc 1-2 clamps to 0.
        add(-1, 0, 0, 0, 4, 1); add(1, 0, 0, 1, 2, 2);
        run_block("blkD", 2, 0);
        // No non-trailing levels.
        run_block("blkE", 3, 3);
        // sl walks 1..6 and saturates; escapes with sl>0.
        add(100, 15, 166, 12); add(100, 15, 138, 12); add(100, 15, 78, 12);
        add(100, 12, 6, 4);    add(-100, 6, 7, 5);    add(100, 3, 6, 6);
        add(100, 3, 6, 6);
        run_block("blkG", 16, 0);

        // Reset while waiting for the downstream finishes.
        iss_q.delete();
        s0 = n_start; d0 = n_done;
        lvl_valid = 1'b1; lvl_data = 16'(5); lvl_last = 1'b0;
        start_block(11, 1);
        pre_dly = 1; suf_dly = 1;
        send_level(5, 1'b0, "rstF");
        wait_start(s0, "rstF");
        pre_dly = 50; suf_dly = 50;
        send_level(1, 1'b1, "rstF");
        wait_start(s0 + 1, "rstF");
        if (iss_q.size() > 1) begin
            check("rstF L0 prefix", 32'(iss_q[0].pfx), 3);
            check("rstF L1 size", 32'(iss_q[1].len), 2);
        end else begin
            check("rstF issued", 32'(iss_q.size()), 2);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst in WAIT outputs", all_outputs(), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rstF no further starts", 32'(n_start - s0), 2);
        check("rstF no blk_done", 32'(n_done - d0), 0);
        check("rstF idle", 32'(busy), 0);
        pre_dly = 1; suf_dly = 1;
        // Fresh block must start from sl=0 again (stale sl=2 would give size 2).
        add(3, 2, 0, 0);
        run_block("postrst", 5, 1);

`ifdef LEVEL_RANGE_CHK_EN
        // +5000 at sl=0: lc 9998, escape 9968 does not fit 12 bits.
        add(5000, 15, 1776, 12);
        run_block("rng", 4, 3);
        check("range_err set", 32'(range_err), 1);
        add(8, 14, 0, 4);
        run_block("rngclr", 4, 3);
        check("range_err cleared", 32'(range_err), 0);
`endif

        check("suffix_start aligned", 32'(ss_mis), 0);
        check("handshake order", 32'(hs_viol), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
